// File: rtl/alu_share_arb.sv
// alu_share_arb: two-port round-robin arbiter that time-shares one
// combinational ALU. A request is accepted in IDLE, the operands are held
// on the ALU for ALU_LAT_CYCLES cycles, Y is registered, and the result is
// returned to the granted port over a valid/ready response handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; arbitration is live
// EXEC  | operands held on the ALU, settle counter running down
// RESP  | registered result offered to the granted requester
module alu_share_arb #(
    parameter int   ALU_LAT_CYCLES = 1,
    parameter logic RR_INIT        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_0,
    input  logic       req_valid_1,
    output logic       req_ready_0,
    output logic       req_ready_1,
    input  logic [3:0] req_a_0,
    input  logic [3:0] req_a_1,
    input  logic [3:0] req_b_0,
    input  logic [3:0] req_b_1,
    input  logic [3:0] req_ctrl_0,
    input  logic [3:0] req_ctrl_1,
    output logic       rsp_valid_0,
    output logic       rsp_valid_1,
    input  logic       rsp_ready_0,
    input  logic       rsp_ready_1,
    output logic [7:0] rsp_y_0,
    output logic [7:0] rsp_y_1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_ctrl,
    input  logic [7:0] alu_y,
    output logic       busy,
    output logic       grant_id
);

    // Counter loads LAT-1 so that LAT=8 fits in 3 bits without wrapping.
    localparam logic [2:0] CNT_LOAD = 3'(ALU_LAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       prio;
    logic       grant_sel;
    logic [2:0] cnt;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] op_ctrl;
    logic [7:0] res_y;
    logic       req_hs;
    logic       rsp_hs;
    logic       exec_done;

    // Arbitration: a lone requester wins, contention goes to the pointer.
    always_comb begin
        grant_sel = prio;
        if (req_valid_0 && !req_valid_1) begin
            grant_sel = 1'b0;
        end else if (req_valid_1 && !req_valid_0) begin
            grant_sel = 1'b1;
        end
    end

    assign req_ready_0 = ~rst & (state == IDLE) & req_valid_0 & ~grant_sel;
    assign req_ready_1 = ~rst & (state == IDLE) & req_valid_1 &  grant_sel;
    assign req_hs      = req_ready_0 | req_ready_1;

    assign rsp_valid_0 = (state == RESP) & ~grant_id;
    assign rsp_valid_1 = (state == RESP) &  grant_id;
    assign rsp_hs      = (rsp_valid_0 & rsp_ready_0) | (rsp_valid_1 & rsp_ready_1);

    assign exec_done   = (state == EXEC) && (cnt == 3'd0);

    // Both result ports show the register; only the granted rsp_valid qualifies it.
    assign rsp_y_0  = res_y;
    assign rsp_y_1  = res_y;
    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_ctrl = op_ctrl;
    assign busy     = (state != IDLE);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs)    state_nxt = EXEC;
            EXEC:    if (exec_done) state_nxt = RESP;
            RESP:    if (rsp_hs)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register; a reset in EXEC or RESP simply drops the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, settle counter, result capture and priority update.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= RR_INIT;
            grant_id <= 1'b0;
            cnt      <= 3'd0;
            op_a     <= 4'd0;
            op_b     <= 4'd0;
            op_ctrl  <= 4'd0;
            res_y    <= 8'd0;
        end else begin
            if (req_hs) begin
                op_a     <= grant_sel ? req_a_1    : req_a_0;
                op_b     <= grant_sel ? req_b_1    : req_b_0;
                op_ctrl  <= grant_sel ? req_ctrl_1 : req_ctrl_0;
                grant_id <= grant_sel;
                cnt      <= CNT_LOAD;
            end else if ((state == EXEC) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (exec_done) begin
                res_y <= alu_y;
            end
            if (rsp_hs) begin
                prio <= ~grant_id;
            end
        end
    end

endmodule
